// File: rtl/hk_pkg.sv
// Shared constants and types for the housekeeping device-DNA reader.
package hk_pkg;

    localparam int unsigned DNA_W       = 57;
    localparam int unsigned DNA_CLK_DIV = 16;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StShift,
        StDone
    } dna_state_t;

endpackage

// File: rtl/hk_dna_clkgen.sv
// Divided clock for the DNA port primitive, plus the sample and end-of-period strobes.
module hk_dna_clkgen import hk_pkg::*; #(
    parameter int unsigned CLK_DIV = DNA_CLK_DIV
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic en_i,
    output logic dna_clk_o,
    output logic sample_o,
    output logic eop_o
);

    localparam int unsigned CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CntMax   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CntHalf  = CW'(CLK_DIV / 2);
    localparam logic [CW-1:0] SampleAt = CW'(CLK_DIV / 2 - 1);

    if (CLK_DIV < 2 || (CLK_DIV % 2) != 0) begin : g_bad_div
        $error("hk_dna_clkgen: CLK_DIV must be even and >= 2");
    end

    logic [CW-1:0] cnt_q, cnt_d;
    logic          dna_clk_q;

    always_comb begin
        cnt_d = '0;
        if (en_i) begin
            cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + CW'(1);
        end
    end

    // Clock is derived from the next count so it stays phase-aligned with cnt_q.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q     <= '0;
            dna_clk_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            dna_clk_q <= (cnt_d >= CntHalf);
        end
    end

    assign dna_clk_o = dna_clk_q;
    assign sample_o  = en_i && (cnt_q == SampleAt);
    assign eop_o     = en_i && (cnt_q == CntMax);

endmodule

// File: rtl/hk_dna_reader.sv
// Reads the FPGA device DNA serially and holds it as a parallel shadow word with a done flag.
module hk_dna_reader import hk_pkg::*; #(
    parameter int unsigned DW         = DNA_W,
    parameter int unsigned CLK_DIV    = DNA_CLK_DIV,
    parameter bit          AUTO_START = 1'b1
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          restart_i,
    output logic          dna_clk_o,
    output logic          dna_read_o,
    output logic          dna_shift_o,
    input  logic          dna_dout_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [DW-1:0] value_o
);

    localparam int unsigned BW = $clog2(DW);

    dna_state_t    state_q, state_d;
    logic          first_q;
    logic          start;
    logic          en, sample, eop;
    logic [BW-1:0] bitcnt_q;
    logic          last_q;
    logic [DW-1:0] sr_q;
    logic [DW-1:0] value_q;

    hk_dna_clkgen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .en_i      (en),
        .dna_clk_o (dna_clk_o),
        .sample_o  (sample),
        .eop_o     (eop)
    );

    assign start = (AUTO_START && first_q) || restart_i;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= StIdle;
            first_q <= 1'b1;
        end else begin
            state_q <= state_d;
            first_q <= 1'b0;
        end
    end

    // restart_i is only honoured when idle or done; a busy readout is never requeued.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: if (start)          state_d = StRead;
            StRead:         if (eop)            state_d = StShift;
            StShift:        if (eop && last_q)  state_d = StDone;
            default:                            state_d = StIdle;
        endcase
    end

    always_comb begin
        busy_o      = 1'b0;
        done_o      = 1'b0;
        dna_read_o  = 1'b0;
        dna_shift_o = 1'b0;
        unique case (state_q)
            StRead: begin
                busy_o     = 1'b1;
                dna_read_o = 1'b1;
            end
            StShift: begin
                busy_o      = 1'b1;
                dna_shift_o = 1'b1;
            end
            StDone:  done_o = 1'b1;
            default: ;
        endcase
    end

    assign en = busy_o;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            bitcnt_q <= '0;
            last_q   <= 1'b0;
            sr_q     <= '0;
            value_q  <= '0;
        end else begin
            if (state_q == StRead && eop) begin
                bitcnt_q <= '0;
                last_q   <= 1'b0;
            end else if (state_q == StShift && sample) begin
                sr_q <= {sr_q[DW-2:0], dna_dout_i};
                if (bitcnt_q == BW'(DW - 1)) begin
                    last_q <= 1'b1;
                end else begin
                    bitcnt_q <= bitcnt_q + BW'(1);
                end
            end
            // Shadow word only moves on entry to done, so a re-read never exposes partial data.
            if (state_q == StShift && eop && last_q) begin
                value_q <= sr_q;
            end
        end
    end

    assign value_o = value_q;

endmodule

// File: tb/tb_hk_dna_reader.sv
// Scoreboard bench for hk_dna_reader: default instance plus a CLK_DIV=2 / DW=8 variant.
module tb_hk_dna_reader;

    localparam int LAT1 = 929;
    localparam int LAT2 = 19;
    localparam logic [56:0] V1 = 57'h0823456789ABCDE;
    localparam logic [56:0] V2 = 57'h1FFFFFFFFFFFFFF;
    localparam logic [56:0] V3 = 57'h1234567890ABCDE;

    logic clk = 1'b0;
    always #4 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rstn1, restart1, dclk1, drd1, dsh1, ddout1, busy1, done1;
    logic [56:0] val1;
    logic        rstn2, restart2, dclk2, drd2, dsh2, ddout2, busy2, done2;
    logic [7:0]  val2;

    hk_dna_reader u_dut1 (
        .clk_i       (clk),
        .rstn_i      (rstn1),
        .restart_i   (restart1),
        .dna_clk_o   (dclk1),
        .dna_read_o  (drd1),
        .dna_shift_o (dsh1),
        .dna_dout_i  (ddout1),
        .busy_o      (busy1),
        .done_o      (done1),
        .value_o     (val1)
    );

    hk_dna_reader #(
        .DW         (8),
        .CLK_DIV    (2),
        .AUTO_START (1'b1)
    ) u_dut2 (
        .clk_i       (clk),
        .rstn_i      (rstn2),
        .restart_i   (restart2),
        .dna_clk_o   (dclk2),
        .dna_read_o  (drd2),
        .dna_shift_o (dsh2),
        .dna_dout_i  (ddout2),
        .busy_o      (busy2),
        .done_o      (done2),
        .value_o     (val2)
    );

    // DNA_PORT models: parallel load on READ, MSB-first shift on SHIFT.
    logic [56:0] model1_val = '0, model1_reg = '0;
    logic [7:0]  model2_val = '0, model2_reg = '0;
    always @(posedge dclk1) begin
        if (drd1)      model1_reg <= model1_val;
        else if (dsh1) model1_reg <= {model1_reg[55:0], 1'b0};
    end
    always @(posedge dclk2) begin
        if (drd2)      model2_reg <= model2_val;
        else if (dsh2) model2_reg <= {model2_reg[6:0], 1'b0};
    end
    assign ddout1 = model1_reg[56];
    assign ddout2 = model2_reg[7];

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [56:0] val;
        int          at;
    } exp_t;
    exp_t sb1[$];
    exp_t sb2[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor 1: handshake statistics plus scoreboard pop on each done_o rise.
    initial begin
        logic p_dclk, p_rd, p_sh, p_done, seen_fall;
        int   cnt_r, cnt_s, hi_len, lo_len, last_rise, last_chg, tim_err;
        exp_t e;
        p_dclk = 0; p_rd = 0; p_sh = 0; p_done = 0; seen_fall = 0;
        cnt_r = 0; cnt_s = 0; hi_len = 0; lo_len = 0; tim_err = 0;
        last_rise = -100; last_chg = -100;
        forever begin
            @(negedge clk);
            if (!rstn1) begin
                p_dclk = 0; p_rd = 0; p_sh = 0; p_done = 0; seen_fall = 0;
                cnt_r = 0; cnt_s = 0; hi_len = 0; lo_len = 0; tim_err = 0;
                last_rise = -100; last_chg = -100;
            end else begin
                if (dclk1 && !p_dclk) begin
                    if (drd1) cnt_r++;
                    if (dsh1) cnt_s++;
                    if (seen_fall && lo_len != 8) tim_err++;
                    if (cyc - last_chg < 2) tim_err++;
                    last_rise = cyc;
                    hi_len = 1;
                end else if (!dclk1 && p_dclk) begin
                    if (hi_len != 8) tim_err++;
                    seen_fall = 1;
                    lo_len = 1;
                end else if (dclk1) begin
                    hi_len++;
                end else begin
                    lo_len++;
                end
                if (drd1 != p_rd || dsh1 != p_sh) begin
                    last_chg = cyc;
                    if (cyc - last_rise < 2) tim_err++;
                end
                if (!busy1) seen_fall = 0;
                if (done1 && !p_done) begin
                    if (sb1.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL dut1_spurious_done: got done_o=1, expected no readout (cycle %0d)",
                                 cyc);
                    end else begin
                        e = sb1.pop_front();
                        check("dut1_value", val1, e.val);
                        check("dut1_latency", cyc, e.at);
                        check("dut1_read_edges", cnt_r, 1);
                        check("dut1_shift_edges", cnt_s, 57);
                        check("dut1_clk_timing_errors", tim_err, 0);
                    end
                    cnt_r = 0; cnt_s = 0; tim_err = 0;
                end
                p_dclk = dclk1; p_rd = drd1; p_sh = dsh1; p_done = done1;
            end
        end
    end

    initial begin
        logic p_done;
        exp_t e;
        p_done = 0;
        forever begin
            @(negedge clk);
            if (!rstn2) begin
                p_done = 0;
            end else begin
                if (done2 && !p_done) begin
                    if (sb2.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL dut2_spurious_done: got done_o=1, expected no readout (cycle %0d)",
                                 cyc);
                    end else begin
                        e = sb2.pop_front();
                        check("dut2_value", {56'd0, val2}, e.val);
                        check("dut2_latency", cyc, e.at);
                    end
                end
                p_done = done2;
            end
        end
    end

    task automatic wait_rel(input int b, input int n);
        while (cyc - b < n) @(negedge clk);
    endtask

    task automatic wait_drain(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (sb1.size() == 0 && sb2.size() == 0) return;
            @(negedge clk);
        end
        if (sb1.size() != 0 || sb2.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_timeout: got %0d+%0d pending readouts, expected 0",
                     sb1.size(), sb2.size());
            sb1.delete();
            sb2.delete();
        end
    endtask

    initial begin
        int base;
        rstn1 = 1'b0; restart1 = 1'b0;
        rstn2 = 1'b0; restart2 = 1'b0;
        model1_val = V1;
        model2_val = 8'hA5;
        repeat (3) @(negedge clk);
        check("reset_ctrl1", {busy1, done1, dclk1, drd1, dsh1}, 0);
        check("reset_value1", val1, 0);
        check("reset_ctrl2", {busy2, done2, dclk2, drd2, dsh2, val2}, 0);

        // Power-on readout with an ignored restart at cycle 300.
        rstn1 = 1'b1;
        base = cyc;
        sb1.push_back('{val: V1, at: base + LAT1});
        wait_rel(base, 300);
        check("busy_at_300", busy1, 1);
        restart1 = 1'b1;
        @(negedge clk);
        restart1 = 1'b0;
        wait_drain(2000);
        repeat (4) @(negedge clk);
        check("idle_busy", busy1, 0);
        check("idle_dna_clk", dclk1, 0);
        check("idle_done", done1, 1);
        check("idle_value", val1, V1);

        // Re-read: shadow value must hold until the new readout completes.
        model1_val = V2;
        restart1 = 1'b1;
        base = cyc;
        sb1.push_back('{val: V2, at: base + LAT1});
        @(negedge clk);
        restart1 = 1'b0;
        check("reread_done_drop", done1, 0);
        check("reread_busy", busy1, 1);
        check("reread_value_held", val1, V1);
        wait_rel(base, 500);
        check("reread_value_held_mid", val1, V1);
        wait_drain(2000);

        // Reset in the middle of shifting, then a fresh automatic readout.
        model1_val = V3;
        rstn1 = 1'b0;
        @(negedge clk);
        rstn1 = 1'b1;
        base = cyc;
        sb1.push_back('{val: V3, at: base + LAT1});
        wait_rel(base, 500);
        check("midreset_shifting", dsh1, 1);
        rstn1 = 1'b0;
        #1;
        check("midreset_ctrl", {busy1, done1, dclk1, drd1, dsh1}, 0);
        check("midreset_value", val1, 0);
        sb1.delete();
        @(negedge clk);
        rstn1 = 1'b1;
        base = cyc;
        sb1.push_back('{val: V3, at: base + LAT1});
        wait_drain(2000);

        // Small variant: CLK_DIV=2, DW=8.
        @(negedge clk);
        rstn2 = 1'b1;
        base = cyc;
        sb2.push_back('{val: 57'hA5, at: base + LAT2});
        wait_drain(200);
        repeat (2) @(negedge clk);
        check("dut2_idle", {busy2, done2, dclk2}, 3'b010);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
